// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 2-FF synchroniser, 3-sample majority vote per bit, parity/framing/break detection.
// Latency: ready pulses at t0 + (N-1)*OVERSAMPLE + OVERSAMPLE/2 + 2; no backpressure, each word is presented once on a ready pulse.
module uart_rx_ovs #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    output logic [DATA_BITS-1:0] out,
    output logic                 ready,
    output logic                 perr,
    output logic                 ferr,
    output logic                 busy
);
    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2;

    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] C_PRE  = CW'(MID - 1);
    localparam logic [CW-1:0] C_MID  = CW'(MID);
    localparam logic [CW-1:0] C_DEC  = CW'(MID + 1);
    localparam logic [3:0]    B_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    B_STOP = 4'(STOP_BITS - 1);
    localparam logic          ODD    = (PARITY == 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t               state;
    logic                 s_meta, s;
    logic [CW-1:0]        cnt;
    logic [3:0]           bitn;
    logic [DATA_BITS-1:0] shreg;
    logic                 v_pre, v_mid;
    logic                 perr_acc, ferr_acc;
    logic                 maj, dec, wrap;

    assign maj  = (v_pre & v_mid) | (v_pre & s) | (v_mid & s);
    assign dec  = (cnt == C_DEC);
    assign wrap = (cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            s_meta   <= 1'b1;
            s        <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            bitn     <= '0;
            shreg    <= '0;
            v_pre    <= 1'b1;
            v_mid    <= 1'b1;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
            out      <= '0;
            ready    <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            s_meta <= in;
            s      <= s_meta;
            ready  <= 1'b0;
            if (cnt == C_PRE) v_pre <= s;
            if (cnt == C_MID) v_mid <= s;
            cnt <= wrap ? '0 : cnt + 1'b1;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    // the low sample itself is sample 0 of the start bit
                    if (!s) begin
                        state    <= START;
                        cnt      <= CW'(1);
                        busy     <= 1'b1;
                        bitn     <= '0;
                        perr_acc <= 1'b0;
                        ferr_acc <= 1'b0;
                    end
                end
                START: begin
                    if (dec && maj) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (dec) shreg <= {maj, shreg[DATA_BITS-1:1]};
                    if (wrap) begin
                        if (bitn == B_DATA) begin
                            bitn  <= '0;
                            state <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bitn <= bitn + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (dec) perr_acc <= (^shreg) ^ maj ^ ODD;
                    if (wrap) state <= STOP;
                end
                STOP: begin
                    if (dec && !maj) ferr_acc <= 1'b1;
                    // commit at the last stop decision so a fast sender can resync
                    if (dec && bitn == B_STOP) begin
                        out   <= shreg;
                        perr  <= perr_acc;
                        ferr  <= ferr_acc | ~maj;
                        ready <= 1'b1;
                        cnt   <= '0;
                        bitn  <= '0;
                        if ((ferr_acc | ~maj) && shreg == '0) begin
                            state <= BRK;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (wrap) begin
                        bitn <= bitn + 1'b1;
                    end
                end
                BRK: begin
                    cnt <= '0;
                    if (s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs (8 data bits, 8x oversampling, even parity, 1 stop bit).
// A frame-level model predicts each committed word and its arrival cycle; a per-cycle checker compares.
module tb_uart_rx_ovs;
    localparam int DB  = 8;
    localparam int OS  = 8;
    localparam int NB  = 1 + DB + 1 + 1;
    localparam int LAT = 4 + (NB - 1) * OS + OS / 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          line = 1'b1;
    logic [DB-1:0] dout;
    logic          ready, perr, ferr, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [DB-1:0] d;
        logic          p;
        logic          f;
        int            c;
    } exp_t;
    exp_t q[$];

    logic [DB-1:0] m_out  = '0;
    logic          m_perr = 1'b0;
    logic          m_ferr = 1'b0;
    logic          ready_prev = 1'b0;
    int            last_ready_cyc = 0;

    uart_rx_ovs #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS),
        .PARITY    (2),
        .STOP_BITS (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .in   (line),
        .out  (dout),
        .ready(ready),
        .perr (perr),
        .ferr (ferr),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serial transmitter: start, LSB-first data, even parity (optionally inverted), stop.
    // A one-cycle inverted glitch may be placed at (gbit, gofs).
    task automatic send_frame(input logic [DB-1:0] d, input bit pflip, input bit stopv,
                              input int gbit, input int gofs);
        logic bits [NB];
        exp_t e;
        bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) bits[1+i] = d[i];
        bits[DB+1] = (^d) ^ pflip;
        bits[DB+2] = stopv;
        e.d = d;
        e.p = pflip;
        e.f = ~stopv;
        e.c = cyc + LAT;
        q.push_back(e);
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < OS; j++) begin
                line = bits[b] ^ ((b == gbit) && (j == gofs));
                tick(1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            m_out      = '0;
            m_perr     = 1'b0;
            m_ferr     = 1'b0;
            ready_prev = 1'b0;
        end else begin
            if (ready) begin
                chk("ready_width", {31'd0, ready_prev}, 32'd0);
                if (q.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out", {24'd0, dout}, {24'd0, e.d});
                    chk("perr", {31'd0, perr}, {31'd0, e.p});
                    chk("ferr", {31'd0, ferr}, {31'd0, e.f});
                    chk("ready_time_ok",
                        {31'd0, (cyc >= e.c - 1) && (cyc <= e.c + 1)}, 32'd1);
                    m_out  = e.d;
                    m_perr = e.p;
                    m_ferr = e.f;
                end
                last_ready_cyc = cyc;
            end else begin
                chk("hold_out", {24'd0, dout}, {24'd0, m_out});
                chk("hold_flags", {30'd0, perr, ferr}, {30'd0, m_perr, m_ferr});
                if (q.size() > 0 && cyc > q[0].c + 1) begin
                    chk("missed_ready", 32'd0, 32'd1);
                    void'(q.pop_front());
                end
            end
            ready_prev = ready;
        end
    end

    initial begin
        int c0;
        int nb;

        // reset
        tick(4);
        @(negedge clk);
        chk("rst_out", {24'd0, dout}, 32'd0);
        chk("rst_flags", {28'd0, ready, perr, ferr, busy}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(10);

        // 1: back-to-back frames
        c0 = cyc;
        send_frame(8'hA9, 0, 1, -1, 0);
        send_frame(8'h99, 0, 1, -1, 0);
        send_frame(8'hB1, 0, 1, -1, 0);
        send_frame(8'hEA, 0, 1, -1, 0);
        tick(4);
        chk("lit_last_word", {24'd0, dout}, 32'hEA);
        chk("lit_latency", last_ready_cyc - c0, 32'd352);
        tick(20);

        // 2: short low pulse is a false start; majority vote hides a glitch
        line = 1'b0;
        tick(2);
        line = 1'b1;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) nb++;
        end
        @(posedge clk);
        #1;
        chk("false_start_busy", nb, 32'd5);
        chk("false_start_out", {24'd0, dout}, 32'hEA);
        tick(10);
        send_frame(8'h55, 0, 1, 4, 4);
        tick(4);
        chk("lit_glitch_out", {24'd0, dout}, 32'h55);
        tick(20);

        // 3: parity error, then a clean frame clears it
        c0 = cyc;
        send_frame(8'h01, 1, 1, -1, 0);
        tick(4);
        chk("lit_perr", {31'd0, perr}, 32'd1);
        chk("lit_perr_latency", last_ready_cyc - c0, 32'd88);
        send_frame(8'h02, 0, 1, -1, 0);
        tick(4);
        chk("lit_perr_cleared", {31'd0, perr}, 32'd0);
        tick(20);

        // 4: framing error, line then idles
        send_frame(8'h3C, 0, 0, -1, 0);
        line = 1'b1;
        tick(30);
        chk("lit_ferr", {31'd0, ferr}, 32'd1);
        chk("ferr_idle_busy", {31'd0, busy}, 32'd0);

        // 5: break (line low 30 bit times)
        send_frame(8'h00, 0, 0, -1, 0);
        tick(30 * OS - NB * OS);
        chk("break_busy", {31'd0, busy}, 32'd1);
        chk("lit_break_out", {24'd0, dout}, 32'h00);
        line = 1'b1;
        tick(16);
        chk("break_exit_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h7E, 0, 1, -1, 0);
        tick(4);
        chk("lit_after_break", {23'd0, ferr, dout}, 32'h07E);
        tick(20);

        // 6: reset during data bit 4 of 0xFF
        line = 1'b0;
        tick(OS);
        line = 1'b1;
        tick(4 * OS + 4);
        chk("mid_frame_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(10);
        chk("post_reset_out", {24'd0, dout}, 32'd0);
        chk("post_reset_flags", {28'd0, ready, perr, ferr, busy}, 32'd0);
        send_frame(8'h12, 0, 1, -1, 0);
        tick(4);
        chk("lit_after_reset", {24'd0, dout}, 32'h12);

        tick(100);
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
